// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a slot-multiplexed link.
// One sample arrives per din_valid cycle. frame_sync marks slot 0.
// Samples are collected into per-slot shadow registers. A complete frame is
// published on dout together with a one-cycle dout_valid pulse.
// Optional feature macro: TDM_DEMUX_ERR_CNT_EN. When it is defined, a
// saturating framing-error counter drives err_count. When it is not defined,
// err_count is tied to 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// HUNT   | not aligned; drop samples until one arrives with frame_sync
// LOCKED | aligned; slot tracks the position of the next accepted sample

module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic                      frame_err,
    output logic                      locked,
    output logic [SW-1:0]             slot,
    output logic [7:0]                err_count
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    state_t                      state_q, state_d;
    logic [SW-1:0]               slot_q, slot_d;
    logic [WIDTH-1:0]            shadow [CHANNELS-1];
    logic [CHANNELS*WIDTH-1:0]   dout_q;
    logic [CHANNELS*WIDTH-1:0]   frame_next;
    logic                        dout_valid_q;
    logic                        frame_err_q;
    logic                        wr_en;
    logic [SW-1:0]               wr_idx;
    logic                        complete;
    logic                        err;

    // The frame is assembled from the shadow slots. The last channel comes directly from din.
    for (genvar k = 0; k < CHANNELS - 1; k++) begin : g_frame
        assign frame_next[k*WIDTH +: WIDTH] = shadow[k];
    end
    assign frame_next[(CHANNELS-1)*WIDTH +: WIDTH] = din;

    // Next-state logic: slot tracking, shadow write select, completion and error detect.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        wr_en    = 1'b0;
        wr_idx   = slot_q;
        complete = 1'b0;
        err      = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        slot_d  = SW'(1);
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync at any slot restarts the frame. An early sync is also an error.
                        err    = (slot_q != '0);
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        slot_d = SW'(1);
                    end else if (slot_q == '0) begin
                        err     = 1'b1;
                        slot_d  = '0;
                        state_d = HUNT;
                    end else if (slot_q == LAST_SLOT) begin
                        complete = 1'b1;
                        slot_d   = '0;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = slot_q;
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // State, slot counter and single-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_valid_q <= complete;
            frame_err_q  <= err;
        end
    end

    // Shadow capture for slots 0..CHANNELS-2. The shadow is not cleared on error; each slot is overwritten before it is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS - 1; i++) begin
                if (wr_en && (wr_idx == SW'(i))) begin
                    shadow[i] <= din;
                end
            end
        end
    end

    // The output frame loads only when a frame completes, so a partial frame never reaches dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (complete) begin
            dout_q <= frame_next;
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_count_q;

    // Saturating count of framing errors. It updates on the same edge that raises frame_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (err && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign locked     = (state_q == LOCKED);
    assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux at WIDTH=8 and CHANNELS=4.
// The expected value of err_count depends on TDM_DEMUX_ERR_CNT_EN.

module tb_tdm_demux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SW       = $clog2(CHANNELS);

    logic                      clk;
    logic                      rst_n;
    logic [WIDTH-1:0]          din;
    logic                      din_valid;
    logic                      frame_sync;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      dout_valid;
    logic                      frame_err;
    logic                      locked;
    logic [SW-1:0]             slot;
    logic [7:0]                err_count;

    int n_chk  = 0;
    int n_pass = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int exp_err = 0;

    tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .locked     (locked),
        .slot       (slot),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_errcnt(input string tag);
`ifdef TDM_DEMUX_ERR_CNT_EN
        chk(tag, 32'(err_count), 32'(exp_err));
`else
        chk(tag, 32'(err_count), 32'd0);
`endif
    endtask

    // Drive one cycle: inputs change on the falling edge and are sampled 1 ns after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        frame_sync = s;
        @(posedge clk);
        #1;
        dv_cnt = dv_cnt + int'(dout_valid);
        fe_cnt = fe_cnt + int'(frame_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
        rst_n      = 1'b0;
        exp_err    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        #1;
        chk("rst_dout",   dout, 32'd0);
        chk("rst_dv",     32'(dout_valid), 32'd0);
        chk("rst_ferr",   32'(frame_err), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_slot",   32'(slot), 32'd0);
        chk_errcnt("rst_errcnt");
        do_reset();

        // Lock onto the sync sample and deliver one frame.
        step(1, 8'h11, 1);
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_slot1",  32'(slot), 32'd1);
        step(1, 8'h22, 0);
        chk("t1_slot2",  32'(slot), 32'd2);
        step(1, 8'h33, 0);
        chk("t1_dv_early", 32'(dout_valid), 32'd0);
        step(1, 8'h44, 0);
        chk("t1_dout",  dout, 32'h44332211);
        chk("t1_dv",    32'(dout_valid), 32'd1);
        chk("t1_slot0", 32'(slot), 32'd0);
        step(0, 8'h00, 0);
        chk("t1_dv_drop", 32'(dout_valid), 32'd0);
        chk("t1_hold",    dout, 32'h44332211);

        // In HUNT, samples without sync are discarded without raising an error.
        do_reset();
        dv_cnt = 0;
        fe_cnt = 0;
        step(1, 8'hAA, 0);
        chk("t2_hunt_locked", 32'(locked), 32'd0);
        chk("t2_hunt_slot",   32'(slot), 32'd0);
        step(1, 8'hBB, 0);
        step(1, 8'h01, 1);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        step(1, 8'h04, 0);
        chk("t2_dout", dout, 32'h04030201);
        step(0, 8'h00, 0);
        chk("t2_dv_cnt", dv_cnt, 1);
        chk("t2_fe_cnt", fe_cnt, 0);

        // Gapped input: slot holds during the idle cycles between samples.
        dv_cnt = 0;
        step(1, 8'h01, 1);
        repeat (3) step(0, 8'hEE, 0);
        chk("t3_slot_hold1", 32'(slot), 32'd1);
        step(1, 8'h02, 0);
        repeat (3) step(0, 8'hEE, 1);
        chk("t3_slot_hold2", 32'(slot), 32'd2);
        step(1, 8'h03, 0);
        repeat (3) step(0, 8'hEE, 0);
        chk("t3_slot_hold3", 32'(slot), 32'd3);
        chk("t3_no_dv_yet",  dv_cnt, 0);
        step(1, 8'h04, 0);
        chk("t3_dv",   32'(dout_valid), 32'd1);
        chk("t3_dout", dout, 32'h04030201);
        step(0, 8'h00, 0);
        chk("t3_dv_drop", 32'(dout_valid), 32'd0);

        // Early resync: the partial frame is discarded and the count of errors increments.
        step(1, 8'h10, 1);
        chk("t4_no_err", 32'(frame_err), 32'd0);
        step(1, 8'h20, 0);
        step(1, 8'h30, 1);
        exp_err++;
        chk("t4_ferr",   32'(frame_err), 32'd1);
        chk("t4_slot",   32'(slot), 32'd1);
        chk("t4_locked", 32'(locked), 32'd1);
        chk_errcnt("t4_errcnt");
        step(1, 8'h40, 0);
        chk("t4_ferr_drop", 32'(frame_err), 32'd0);
        step(1, 8'h50, 0);
        step(1, 8'h60, 0);
        chk("t4_dout", dout, 32'h60504030);
        chk("t4_dv",   32'(dout_valid), 32'd1);

        // Lost sync: a sample without sync at slot 0 causes a return to HUNT.
        step(1, 8'h77, 0);
        exp_err++;
        chk("t5_ferr",   32'(frame_err), 32'd1);
        chk("t5_locked", 32'(locked), 32'd0);
        chk("t5_slot",   32'(slot), 32'd0);
        chk("t5_dout",   dout, 32'h60504030);
        chk("t5_dv",     32'(dout_valid), 32'd0);
        chk_errcnt("t5_errcnt");
        step(1, 8'h88, 0);
        chk("t5_ferr_drop", 32'(frame_err), 32'd0);
        chk("t5_hunt_dout", dout, 32'h60504030);

        // Asserting reset mid-frame clears all outputs immediately, before the next clock edge.
        step(1, 8'hA1, 1);
        step(1, 8'hA2, 0);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        exp_err   = 0;
        #1;
        chk("t6_dout",   dout, 32'd0);
        chk("t6_locked", 32'(locked), 32'd0);
        chk("t6_slot",   32'(slot), 32'd0);
        chk("t6_dv",     32'(dout_valid), 32'd0);
        chk("t6_ferr",   32'(frame_err), 32'd0);
        chk_errcnt("t6_errcnt");
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'hB1, 1);
        step(1, 8'hB2, 0);
        step(1, 8'hB3, 0);
        step(1, 8'hB4, 0);
        chk("t6_dout_after", dout, 32'hB4B3B2B1);
        chk("t6_dv_after",   32'(dout_valid), 32'd1);

        // Back-to-back frames produce one dout_valid every CHANNELS cycles.
        dv_cnt = 0;
        step(1, 8'hC1, 1);
        step(1, 8'hC2, 0);
        step(1, 8'hC3, 0);
        step(1, 8'hC4, 0);
        chk("t7_dout1", dout, 32'hC4C3C2C1);
        step(1, 8'hD1, 1);
        step(1, 8'hD2, 0);
        step(1, 8'hD3, 0);
        step(1, 8'hD4, 0);
        chk("t7_dout2",  dout, 32'hD4D3D2D1);
        chk("t7_dv_cnt", dv_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
